alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_divider.sv | 75 +++++++
 rtl/alu_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: op-codes, FSM states and the "does this op iterate" decision.
// Honours ALU_SEQ_MUL_EN: without it, mul is a single-cycle op returning zero.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

    localparam int ALU_OP_W = 3;

    // Division by zero short-circuits, so only a non-zero divisor needs the iterative path.
    function automatic logic op_needs_run(input alu_op_t op, input logic b_is_zero);
        logic run_s;
        case (op)
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:         run_s = 1'b1;
`endif
            OP_DIV, OP_MOD: run_s = ~b_is_zero;
            default:        run_s = 1'b0;
        endcase
        return run_s;
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, the first produced on the start edge,
// so done pulses in the cycle after the Nth step with quotient/remainder held until the next start.
module alu_seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  r_q;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_d;
    logic [CW-1:0] r_cnt;
    logic          r_active;
    logic          r_done;

    logic [N-1:0]  w_src_q;
    logic [N-1:0]  w_src_rem;
    logic [N-1:0]  w_src_d;
    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic          w_fits;
    logic [N-1:0]  w_rem_next;
    logic [N-1:0]  w_q_next;

    assign w_src_q    = start ? dividend : r_q;
    assign w_src_rem  = start ? {N{1'b0}} : r_rem;
    assign w_src_d    = start ? divisor : r_d;
    assign w_shift    = {w_src_rem, w_src_q[N-1]};
    assign w_trial    = w_shift - {1'b0, w_src_d};
    assign w_fits     = ~w_trial[N];
    assign w_rem_next = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
    assign w_q_next   = {w_src_q[N-2:0], w_fits};

    // Step the division on start and on every active cycle until N bits are produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= {N{1'b0}};
            r_rem    <= {N{1'b0}};
            r_d      <= {N{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_q      <= w_q_next;
                r_rem    <= w_rem_next;
                r_d      <= divisor;
                r_cnt    <= CW'(1);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_q   <= w_q_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_rem;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, N-cycle shift-add multiply and restoring divide.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise mul returns zero in one cycle.
module alu_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         carry,
    output logic         div0
);
    import alu_seq_pkg::*;

    alu_state_t   r_state, w_state_next;
    alu_op_t      r_op, w_op_in;
    logic [N-1:0] r_result, r_result_hi, w_result_next, w_result_hi_next;
    logic         r_busy, r_done, r_zero, r_carry, r_div0;
    logic         w_busy_next, w_done_next, w_zero_next, w_carry_next, w_div0_next;
    logic         w_load, w_div_start, w_div_done, w_b_zero;
    logic [N-1:0] w_quo, w_rem;
    logic [N:0]   w_sum, w_diff;
    logic [N-1:0] w_sc_lo, w_sc_hi;
    logic         w_sc_carry, w_sc_div0;
    logic [N-1:0] w_run_lo, w_run_hi;
    logic         w_run_last;

    assign w_op_in  = alu_op_t'(op);
    assign w_b_zero = (b == {N{1'b0}});
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};

    // Results of ops that finish on the start edge (div/mod only land here with b == 0).
    always_comb begin
        w_sc_lo    = {N{1'b0}};
        w_sc_hi    = {N{1'b0}};
        w_sc_carry = 1'b0;
        w_sc_div0  = 1'b0;
        case (w_op_in)
            OP_ADD: begin
                w_sc_lo    = w_sum[N-1:0];
                w_sc_carry = w_sum[N];
            end
            OP_SUB: begin
                w_sc_lo    = w_diff[N-1:0];
                w_sc_carry = w_diff[N];
            end
            OP_DIV: begin
                w_sc_lo   = {N{1'b1}};
                w_sc_div0 = 1'b1;
            end
            OP_MOD: begin
                w_sc_lo   = a;
                w_sc_div0 = 1'b1;
            end
            OP_AND:  w_sc_lo = a & b;
            OP_OR:   w_sc_lo = a | b;
            OP_XOR:  w_sc_lo = a ^ b;
            default: w_sc_lo = {N{1'b0}};
        endcase
    end

    alu_seq_divider #(.N(N)) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_prod, w_prod_next;
    logic [CW-1:0]  r_cnt;
    logic [N:0]     w_mul_sum;

    // Multiplier lives in the low half of r_prod and shifts out as the product shifts in.
    assign w_mul_sum   = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_b} : {(N+1){1'b0}});
    assign w_prod_next = {w_mul_sum, r_prod[N-1:1]};

    // Capture multiplier operands on start and iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b    <= {N{1'b0}};
            r_prod <= {(2*N){1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else if (w_load) begin
            r_b    <= b;
            r_prod <= {{N{1'b0}}, a};
            r_cnt  <= {CW{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Select the finishing condition and result source for the running op.
    always_comb begin
        if (r_op == OP_MUL) begin
            w_run_last = (r_cnt == CW'(N - 1));
            w_run_lo   = w_prod_next[N-1:0];
            w_run_hi   = w_prod_next[2*N-1:N];
        end else begin
            w_run_last = w_div_done;
            w_run_lo   = (r_op == OP_DIV) ? w_quo : w_rem;
            w_run_hi   = {N{1'b0}};
        end
    end
`else
    assign w_run_last = w_div_done;
    assign w_run_lo   = (r_op == OP_DIV) ? w_quo : w_rem;
    assign w_run_hi   = {N{1'b0}};
`endif

    // FSM next state and next values of the registered outputs.
    always_comb begin
        w_state_next     = r_state;
        w_result_next    = r_result;
        w_result_hi_next = r_result_hi;
        w_zero_next      = r_zero;
        w_carry_next     = r_carry;
        w_div0_next      = r_div0;
        w_busy_next      = 1'b0;
        w_done_next      = 1'b0;
        w_load           = 1'b0;
        w_div_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (op_needs_run(w_op_in, w_b_zero)) begin
                        w_state_next = ST_RUN;
                        w_busy_next  = 1'b1;
                        w_div_start  = (w_op_in == OP_DIV) || (w_op_in == OP_MOD);
                    end else begin
                        w_state_next     = ST_DONE;
                        w_done_next      = 1'b1;
                        w_result_next    = w_sc_lo;
                        w_result_hi_next = w_sc_hi;
                        w_zero_next      = ({w_sc_hi, w_sc_lo} == {(2*N){1'b0}});
                        w_carry_next     = w_sc_carry;
                        w_div0_next      = w_sc_div0;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_run_last) begin
                    w_state_next     = ST_DONE;
                    w_done_next      = 1'b1;
                    w_result_next    = w_run_lo;
                    w_result_hi_next = w_run_hi;
                    w_zero_next      = ({w_run_hi, w_run_lo} == {(2*N){1'b0}});
                    w_carry_next     = 1'b0;
                    w_div0_next      = 1'b0;
                end else begin
                    w_busy_next = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, captured op and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_result    <= {N{1'b0}};
            r_result_hi <= {N{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_div0      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_load ? w_op_in : r_op;
            r_result    <= w_result_next;
            r_result_hi <= w_result_hi_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_zero      <= w_zero_next;
            r_carry     <= w_carry_next;
            r_div0      <= w_div0_next;
        end
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign busy      = r_busy;
    assign done      = r_done;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign div0      = r_div0;

endmodule
